// File: rtl/p4_adder_resp.sv
// Responder for the P4 adder request/response protocol: {a,b,cin} in, {s,cout,ovf} out.
// Latency: a response is valid two edges after its request is accepted, counting the accept edge; one result per cycle.
// Backpressure: a two-entry pipeline (stage 1 + output). in_ready drops when both are full and out_ready is low.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    request handshake carrying a, b, cin
//   out_valid/out_ready  response handshake carrying s, cout, ovf
//   txn_cnt              number of retired responses, wraps at 2^CNT_W
module p4_adder_resp #(
  parameter int NBIT  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBIT-1:0]  a,
  input  logic [NBIT-1:0]  b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBIT-1:0]  s,
  output logic             cout,
  output logic             ovf,
  output logic [CNT_W-1:0] txn_cnt
);

  localparam int LO = NBIT / 2;
  localparam int HI = NBIT - LO;

  // Stage-1 payload: low half already summed, high half carried raw together
  // with the carry into it. The operand sign bits are kept separately so the
  // overflow test does not have to reach back into the high-half operands.
  typedef struct packed {
    logic [LO-1:0] lo_sum;
    logic          c_mid;
    logic [HI-1:0] a_hi;
    logic [HI-1:0] b_hi;
    logic          a_msb;
    logic          b_msb;
  } st1_t;

  st1_t            v1_dat;
  logic            v1;
  logic            ld2;
  logic            adv1;
  logic            acc;
  logic            retire;
  logic [LO:0]     lo_full;
  logic [HI:0]     hi_full;
  logic [NBIT-1:0] s_nxt;
  logic            ovf_nxt;

  // Output register can take stage 1 when it is empty or being drained this
  // cycle; stage 1 can take a new request when it is empty or moving on.
  // This gives the out_ready -> in_ready combinational path and lets a
  // retire and a load happen in the same cycle without a bubble.
  assign ld2      = v1 && (!out_valid || out_ready);
  assign adv1     = !v1 || ld2;
  assign in_ready = adv1 && !rst;
  assign acc      = in_valid && in_ready;
  assign retire   = out_valid && out_ready;

  assign lo_full = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]} + {{LO{1'b0}}, cin};
  assign hi_full = {1'b0, v1_dat.a_hi} + {1'b0, v1_dat.b_hi} + {{HI{1'b0}}, v1_dat.c_mid};
  assign s_nxt   = {hi_full[HI-1:0], v1_dat.lo_sum};
  assign ovf_nxt = (v1_dat.a_msb == v1_dat.b_msb) && (s_nxt[NBIT-1] != v1_dat.a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v1_dat <= '0;
    end else if (acc) begin
      v1            <= 1'b1;
      v1_dat.lo_sum <= lo_full[LO-1:0];
      v1_dat.c_mid  <= lo_full[LO];
      v1_dat.a_hi   <= a[NBIT-1:LO];
      v1_dat.b_hi   <= b[NBIT-1:LO];
      v1_dat.a_msb  <= a[NBIT-1];
      v1_dat.b_msb  <= b[NBIT-1];
    end else if (ld2) begin
      v1 <= 1'b0;
    end
  end

  // Data outputs only change on a load, so they stay stable while stalled
  // and keep their last value after the response retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (ld2) begin
      out_valid <= 1'b1;
      s         <= s_nxt;
      cout      <= hi_full[HI];
      ovf       <= ovf_nxt;
    end else if (retire) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt <= '0;
    end else if (retire) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_p4_adder_resp.sv
// Bench for p4_adder_resp: a 32-bit/16-bit-counter instance and a 33-bit/4-bit-counter instance share stimulus.
// Latency: checks exact two-edge request-to-response timing and one-per-cycle throughput.
// Backpressure: exercises stall, release, reset with requests in flight, and random out_ready.
module tb_p4_adder_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, cin;
  logic [32:0] a33, b33;

  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] s;
  logic [15:0] txn_cnt;

  logic        in_ready33, out_valid33, cout33, ovf33;
  logic [32:0] s33;
  logic [3:0]  cnt33;

  int n_cmp = 0;
  int n_err = 0;
  int nret  = 0;

  p4_adder_resp #(.NBIT(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a33[31:0]), .b(b33[31:0]), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .txn_cnt(txn_cnt)
  );

  p4_adder_resp #(.NBIT(33), .CNT_W(4)) dut33 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready33),
    .a(a33), .b(b33), .cin(cin),
    .out_valid(out_valid33), .out_ready(out_ready),
    .s(s33), .cout(cout33), .ovf(ovf33), .txn_cnt(cnt33)
  );

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; a33 = '0; b33 = '0; cin = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready act=%b exp=0", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid act=%b exp=0", out_valid); end
    n_cmp++; if ({cout, ovf, s} !== 34'h0) begin n_err++; $display("FAIL rst_data act=%h exp=0", {cout, ovf, s}); end
    n_cmp++; if (txn_cnt !== 16'h0) begin n_err++; $display("FAIL rst_txn_cnt act=%h exp=0", txn_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready act=%b exp=1", in_ready); end
    n_cmp++; if ({out_valid33, cnt33} !== 5'h0) begin n_err++; $display("FAIL rst_dut33 act=%h exp=0", {out_valid33, cnt33}); end
    nret = 0;
    @(posedge clk);
    #1;
  endtask

  // Single requests on an idle pipeline; hand-computed results for both widths.
  task automatic test_single();
    logic [32:0] ta  [7] = '{33'h0_FFFFFFFF, 33'h0_7FFFFFFF, 33'h0_80000000, 33'h0_0000FFFF,
                             33'h1_FFFFFFFF, 33'h1_00000000, 33'h0_00000000};
    logic [32:0] tb  [7] = '{33'h1, 33'h0, 33'h0_80000000, 33'h1, 33'h1, 33'h1_00000000, 33'h0};
    logic        tc  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [33:0] e32 [7] = '{{1'b1, 1'b0, 32'h00000000}, {1'b0, 1'b1, 32'h80000000},
                             {1'b1, 1'b1, 32'h00000000}, {1'b0, 1'b0, 32'h00010000},
                             {1'b1, 1'b0, 32'h00000000}, {1'b0, 1'b0, 32'h00000000},
                             {1'b0, 1'b0, 32'h00000001}};
    logic [34:0] e33 [7] = '{{1'b0, 1'b1, 33'h1_00000000}, {1'b0, 1'b0, 33'h0_80000000},
                             {1'b0, 1'b1, 33'h1_00000000}, {1'b0, 1'b0, 33'h0_00010000},
                             {1'b1, 1'b0, 33'h0_00000000}, {1'b1, 1'b1, 33'h0_00000000},
                             {1'b0, 1'b0, 33'h0_00000001}};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      a33 = ta[k]; b33 = tb[k]; cin = tc[k]; in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single%0d_in_ready act=%b exp=1", k, in_ready); end
      @(posedge clk);
      #1;
      // Operands change after the handshake and must not leak into the result.
      in_valid = 1'b0; a33 = 33'h1_AAAAAAAA; b33 = 33'h0_55555555; cin = 1'b1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single%0d_early act=%b exp=0", k, out_valid); end
      @(posedge clk);
      #1;
      n_cmp++; if ({out_valid, cout, ovf, s} !== {1'b1, e32[k]})
        begin n_err++; $display("FAIL single%0d_res32 act=%h exp=%h", k, {out_valid, cout, ovf, s}, {1'b1, e32[k]}); end
      n_cmp++; if ({out_valid33, cout33, ovf33, s33} !== {1'b1, e33[k]})
        begin n_err++; $display("FAIL single%0d_res33 act=%h exp=%h", k, {out_valid33, cout33, ovf33, s33}, {1'b1, e33[k]}); end
      @(posedge clk);
      #1;
      nret++;
      n_cmp++; if ({out_valid, txn_cnt} !== {1'b0, 16'(nret)})
        begin n_err++; $display("FAIL single%0d_retire act=%h exp=%h", k, {out_valid, txn_cnt}, {1'b0, 16'(nret)}); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ba [4] = '{32'h00000001, 32'hFFFF0000, 32'h7FFF8000, 32'h12345678};
    logic [31:0] bb [4] = '{32'h00000002, 32'h00010000, 32'h00008000, 32'h11111111};
    logic        bc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [34:0] be [4] = '{{1'b1, 1'b0, 1'b0, 32'h00000003}, {1'b1, 1'b1, 1'b0, 32'h00000000},
                            {1'b1, 1'b0, 1'b1, 32'h80000000}, {1'b1, 1'b0, 1'b0, 32'h2345678A}};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        a33 = {1'b0, ba[i]}; b33 = {1'b0, bb[i]}; cin = bc[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 4) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b%0d_in_ready act=%b exp=1", i, in_ready); end
      end
      if (i >= 2) begin
        n_cmp++; if ({out_valid, cout, ovf, s} !== be[i-2])
          begin n_err++; $display("FAIL b2b%0d_out act=%h exp=%h", i, {out_valid, cout, ovf, s}, be[i-2]); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b%0d_early act=%b exp=0", i, out_valid); end
      end
      @(posedge clk);
      #1;
    end
    nret += 4;
    n_cmp++; if ({out_valid, txn_cnt} !== {1'b0, 16'(nret)})
      begin n_err++; $display("FAIL b2b_txn_cnt act=%h exp=%h", {out_valid, txn_cnt}, {1'b0, 16'(nret)}); end
  endtask

  task automatic test_backpressure();
    int nxt = 0;
    out_ready = 1'b0; cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a33 = 33'(nxt); b33 = 33'(nxt); in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== (i < 2)) begin n_err++; $display("FAIL bp%0d_in_ready act=%b exp=%b", i, in_ready, (i < 2)); end
      if (i >= 2) begin
        n_cmp++; if ({out_valid, s} !== {1'b1, 32'h0})
          begin n_err++; $display("FAIL bp%0d_stall act=%h exp=%h", i, {out_valid, s}, {1'b1, 32'h0}); end
      end
      if (in_ready) nxt++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      if (nxt < 5) begin
        a33 = 33'(nxt); b33 = 33'(nxt); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (nxt < 5) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rel%0d_in_ready act=%b exp=1", j, in_ready); end
      end
      if (j < 5) begin
        n_cmp++; if ({out_valid, s} !== {1'b1, 32'(2 * j)})
          begin n_err++; $display("FAIL rel%0d_out act=%h exp=%h", j, {out_valid, s}, {1'b1, 32'(2 * j)}); end
      end else begin
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rel%0d_drained act=%b exp=0", j, out_valid); end
      end
      if (in_valid && in_ready) nxt++;
      @(posedge clk);
      #1;
    end
    nret += 5;
    n_cmp++; if (txn_cnt !== 16'(nret)) begin n_err++; $display("FAIL bp_txn_cnt act=%h exp=%h", txn_cnt, 16'(nret)); end
    n_cmp++; if (cnt33 !== 4'(nret)) begin n_err++; $display("FAIL bp_cnt33 act=%h exp=%h", cnt33, 4'(nret)); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; cin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a33 = 33'(16'h100 + i); b33 = 33'h1; in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b1; a33 = 33'h77; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready act=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_cmp++; if ({out_valid, txn_cnt} !== 17'h0) begin n_err++; $display("FAIL midrst_state act=%h exp=0", {out_valid, txn_cnt}); end
    n_cmp++; if ({out_valid33, cnt33} !== 5'h0) begin n_err++; $display("FAIL midrst_dut33 act=%h exp=0", {out_valid33, cnt33}); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready_after act=%b exp=1", in_ready); end
    nret = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale%0d act=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1; cin = 1'b0; b33 = '0;
    for (int i = 0; i < 19; i++) begin
      a33 = 33'(i); in_valid = (i < 17);
      @(posedge clk);
      #1;
    end
    nret += 17;
    n_cmp++; if (cnt33 !== 4'd1) begin n_err++; $display("FAIL wrap_cnt33 act=%0d exp=1", cnt33); end
    n_cmp++; if (txn_cnt !== 16'd17) begin n_err++; $display("FAIL wrap_txn_cnt act=%0d exp=17", txn_cnt); end
  endtask

  task automatic test_random();
    logic [33:0] q32 [$];
    logic [34:0] q33 [$];
    logic [33:0] e32;
    logic [34:0] e33;
    logic [32:0] t;
    logic [33:0] u;
    int sent = 0;
    int cyc  = 0;
    while ((sent < 10000 || q32.size() > 0 || q33.size() > 0) && cyc < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      a33 = {1'($urandom_range(0, 1)), 32'($urandom)};
      b33 = {1'($urandom_range(0, 1)), 32'($urandom)};
      cin = 1'($urandom_range(0, 1));
      in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q32.size() == 0) begin
          n_err++; $display("FAIL rnd_unexpected32 act=%h exp=none", {cout, ovf, s});
        end else begin
          e32 = q32.pop_front();
          if ({cout, ovf, s} !== e32) begin n_err++; $display("FAIL rnd_res32 act=%h exp=%h", {cout, ovf, s}, e32); end
        end
        nret++;
      end
      if (out_valid33 && out_ready) begin
        n_cmp++;
        if (q33.size() == 0) begin
          n_err++; $display("FAIL rnd_unexpected33 act=%h exp=none", {cout33, ovf33, s33});
        end else begin
          e33 = q33.pop_front();
          if ({cout33, ovf33, s33} !== e33) begin n_err++; $display("FAIL rnd_res33 act=%h exp=%h", {cout33, ovf33, s33}, e33); end
        end
      end
      if (in_valid && in_ready) begin
        t = {1'b0, a33[31:0]} + {1'b0, b33[31:0]} + 33'(cin);
        q32.push_back({t[32], (a33[31] == b33[31]) && (t[31] != a33[31]), t[31:0]});
        sent++;
      end
      if (in_valid && in_ready33) begin
        u = {1'b0, a33} + {1'b0, b33} + 34'(cin);
        q33.push_back({u[33], (a33[32] == b33[32]) && (u[32] != a33[32]), u[32:0]});
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (sent < 10000 || q32.size() != 0 || q33.size() != 0)
      begin n_err++; $display("FAIL rnd_timeout sent=%0d pending=%0d exp_sent=10000 exp_pending=0", sent, q32.size() + q33.size()); end
    n_cmp++; if (txn_cnt !== 16'(nret)) begin n_err++; $display("FAIL rnd_txn_cnt act=%h exp=%h", txn_cnt, 16'(nret)); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; a33 = '0; b33 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
